// File: rtl/out_stream_arbiter_pkg.sv
// Shared definitions for the outgoing stream arbiter and its round-robin picker.
// Contents: stream width, arbiter state type, ID width helper.
package out_stream_arbiter_pkg;

  localparam int STREAM_W = 128;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Width of an index field able to address n requesters (at least 1 bit).
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_stream_arbiter_if.sv
// Handshake bundle between N requester streams and the merged 128-bit stream.
// slave  : arbiter side (consumes requests, drives merged stream)
// master : environment side (drives requests, consumes merged stream)
//   req_valid[N], req_data[N*128], req_rdy[N]
//   s128_valid, s128_data[128], s128_rdy, s128_id[IDW]
interface out_stream_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = out_stream_arbiter_pkg::id_width(N)
);
  logic [N-1:0]                                 req_valid;
  logic [N*out_stream_arbiter_pkg::STREAM_W-1:0] req_data;
  logic [N-1:0]                                 req_rdy;
  logic                                         s128_valid;
  logic [out_stream_arbiter_pkg::STREAM_W-1:0]   s128_data;
  logic                                         s128_rdy;
  logic [IDW-1:0]                               s128_id;

  modport master (
    output req_valid, req_data, s128_rdy,
    input  req_rdy, s128_valid, s128_data, s128_id
  );

  modport slave (
    input  req_valid, req_data, s128_rdy,
    output req_rdy, s128_valid, s128_data, s128_id
  );
endinterface

// File: rtl/out_stream_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin selector.
// Ports: req_i[N] request vector, last_i index granted last;
//        any_o high if any request, sel_o first requester after last_i (cyclic).
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = out_stream_arbiter_pkg::id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic           any_o,
  output logic [IDW-1:0] sel_o
);

  int idx;

  // Scan from the farthest candidate towards last_i+1 so the nearest hit wins.
  always_comb begin
    any_o = 1'b0;
    sel_o = '0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N;
      if (req_i[idx]) begin
        any_o = 1'b1;
        sel_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/out_stream_arbiter.sv
// out_stream_arbiter: round-robin merge of N 128-bit requester streams onto
// one outgoing stream, with at most BURST beats per grant and one
// arbitration bubble between grants.
// Ports: clk, rst_n (async, active low), s (out_stream_arbiter_if.slave),
//        busy (high while a requester is granted).
// Optional build macro OUT_STREAM_ARB_STATS_EN adds per-requester beat
// counters: stat_sel selects one, stat_beats returns it one cycle later.
module out_stream_arbiter
  import out_stream_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int BURST = 8,
  parameter int IDW   = id_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  out_stream_arbiter_if.slave  s,
  output logic                 busy
`ifdef OUT_STREAM_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]       stat_sel,
  output logic [31:0]          stat_beats
`endif
);

  localparam int CW = $clog2(BURST + 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] g_q, g_d;
  logic [IDW-1:0] last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pick_any;
  logic [IDW-1:0] pick_sel;
  logic           cur_valid;
  logic           hs;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_i  (s.req_valid),
    .last_i (last_q),
    .any_o  (pick_any),
    .sel_o  (pick_sel)
  );

  assign cur_valid = s.req_valid[g_q];
  assign hs        = (state_q == ST_GRANT) && cur_valid && s.s128_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      last_q  <= IDW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          g_d     = pick_sel;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // An empty cycle forfeits the grant; otherwise release on the last beat.
        if (!cur_valid) begin
          last_d  = g_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (hs) begin
          if (cnt_q == CW'(BURST - 1)) begin
            last_d  = g_q;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    s.s128_valid = 1'b0;
    s.s128_data  = '0;
    s.req_rdy    = '0;
    s.s128_id    = g_q;
    busy         = 1'b0;
    if (state_q == ST_GRANT) begin
      s.s128_valid     = cur_valid;
      s.s128_data      = s.req_data[STREAM_W*int'(g_q) +: STREAM_W];
      s.req_rdy[g_q]   = s.s128_rdy;
      busy             = 1'b1;
    end
  end

`ifdef OUT_STREAM_ARB_STATS_EN
  logic [31:0] stat_cnt_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stat_cnt_q[i] <= '0;
      stat_beats <= '0;
    end else begin
      if (hs) stat_cnt_q[g_q] <= stat_cnt_q[g_q] + 32'd1;
      stat_beats <= (int'(stat_sel) < N) ? stat_cnt_q[stat_sel] : 32'd0;
    end
  end
`endif

endmodule

// File: tb/tb_out_stream_arbiter.sv
module tb_out_stream_arbiter;
  localparam int N     = 4;
  localparam int BURST = 8;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  always #5 clk = ~clk;

  out_stream_arbiter_if #(.N(N), .IDW(IDW)) bus ();

`ifdef OUT_STREAM_ARB_STATS_EN
  logic [IDW-1:0] stat_sel;
  logic [31:0]    stat_beats;
`endif

  out_stream_arbiter #(.N(N), .BURST(BURST), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus),
    .busy  (busy)
`ifdef OUT_STREAM_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_beats (stat_beats)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus sources: one FIFO of pending beats per requester.
  logic [127:0] srcq [N][$];
  logic [N-1:0] gate;
  logic         rdy_drv;
  bit           rand_mode;
  int           tcyc;

  // Reference model: who owns the stream, beats in this grant, rotation pointer.
  int m_owner, m_last, m_lastg, m_beats;
  int m_grants[$];
  int m_gbeats[$];
  int m_total[N];

  logic [127:0] obs_data[$];
  int           obs_id[$];
  int           obs_cyc[$];
  logic [127:0] seen_data;
  logic [IDW-1:0] seen_id;

  function automatic logic [127:0] beat(input int req, input int k);
    return 128'((req << 8) | k);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_lastg = 0; m_beats = 0;
    m_grants.delete(); m_gbeats.delete();
    for (int i = 0; i < N; i++) m_total[i] = 0;
    obs_data.delete(); obs_id.delete(); obs_cyc.delete();
    tcyc = 0;
  endtask

  task automatic model_step(input logic [N-1:0] rv, input logic rdy);
    if (m_owner < 0) begin
      if (rv != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (rv[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_lastg = m_owner;
        m_beats = 0;
        m_grants.push_back(m_owner);
        m_gbeats.push_back(0);
      end
    end else if (!rv[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (rdy) begin
      m_beats++;
      m_total[m_owner]++;
      m_gbeats[m_gbeats.size()-1]++;
      if (m_beats == BURST) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic drive_inputs();
    if (rand_mode) begin
      gate    = N'($urandom);
      rdy_drv = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (srcq[i].size() < 3 && $urandom_range(0, 1) == 1)
          srcq[i].push_back({$urandom, $urandom, $urandom, $urandom});
    end
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]            = (srcq[i].size() > 0) && gate[i];
      bus.req_data[128*i +: 128]  = (srcq[i].size() > 0) ? srcq[i][0] : 128'd0;
    end
    bus.s128_rdy = rdy_drv;
  endtask

  // One clock: drive, compare against the model at negedge, advance at posedge.
  task automatic run_cycle();
    logic [N-1:0]   rv, pop, exp_rdy;
    logic           rdy, exp_valid, exp_busy;
    logic [127:0]   exp_data;
    logic [IDW-1:0] exp_id;
    drive_inputs();
    @(negedge clk);
    rv  = bus.req_valid;
    rdy = bus.s128_rdy;
    if (m_owner < 0) begin
      exp_valid = 1'b0; exp_data = '0; exp_rdy = '0;
      exp_id = IDW'(m_lastg); exp_busy = 1'b0;
    end else begin
      exp_valid = rv[m_owner];
      exp_data  = bus.req_data[128*m_owner +: 128];
      exp_rdy   = rdy ? N'(1 << m_owner) : '0;
      exp_id    = IDW'(m_owner);
      exp_busy  = 1'b1;
    end
    n_checks += 6;
    if (bus.s128_valid !== exp_valid) begin
      n_fail++; $display("FAIL s128_valid cyc=%0d got=%b exp=%b", tcyc, bus.s128_valid, exp_valid);
    end
    if (bus.s128_data !== exp_data) begin
      n_fail++; $display("FAIL s128_data cyc=%0d got=%h exp=%h", tcyc, bus.s128_data, exp_data);
    end
    if (bus.req_rdy !== exp_rdy) begin
      n_fail++; $display("FAIL req_rdy cyc=%0d got=%b exp=%b", tcyc, bus.req_rdy, exp_rdy);
    end
    if (bus.s128_id !== exp_id) begin
      n_fail++; $display("FAIL s128_id cyc=%0d got=%0d exp=%0d", tcyc, bus.s128_id, exp_id);
    end
    if (busy !== exp_busy) begin
      n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", tcyc, busy, exp_busy);
    end
    if ($countones(bus.req_rdy) > 1) begin
      n_fail++; $display("FAIL req_rdy_onehot cyc=%0d got=%b", tcyc, bus.req_rdy);
    end
    seen_data = bus.s128_data;
    seen_id   = bus.s128_id;
    if (bus.s128_valid === 1'b1 && rdy === 1'b1) begin
      obs_data.push_back(bus.s128_data);
      obs_id.push_back(int'(bus.s128_id));
      obs_cyc.push_back(tcyc);
    end
    pop = bus.req_rdy & rv;
    @(posedge clk);
    model_step(rv, rdy);
    for (int i = 0; i < N; i++) if (pop[i] === 1'b1) void'(srcq[i].pop_front());
    tcyc++;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rand_mode = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    gate = '1;
    rdy_drv = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_to_idle(input string name, input int budget);
    int n = 0;
    bit pending = 1'b1;
    while (pending && n < budget) begin
      run_cycle();
      n++;
      pending = (m_owner >= 0);
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) pending = 1'b1;
    end
    n_checks++;
    if (pending) begin
      n_fail++; $display("FAIL %s_timeout got=%0d cycles exp<%0d", name, n, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    gate = '1; rdy_drv = 1'b1;
    drive_inputs();
    #3;
    n_checks += 5;
    if (bus.s128_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.s128_valid); end
    if (bus.s128_data !== '0)    begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.s128_data); end
    if (bus.req_rdy !== '0)      begin n_fail++; $display("FAIL reset_req_rdy got=%b exp=0", bus.req_rdy); end
    if (bus.s128_id !== '0)      begin n_fail++; $display("FAIL reset_id got=%0d exp=0", bus.s128_id); end
    if (busy !== 1'b0)           begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    apply_reset();
    rdy_drv = 1'b1;
    repeat (3) run_cycle();
  endtask

  task automatic test_single();
    apply_reset();
    rdy_drv = 1'b1;
    for (int k = 0; k < 3; k++) srcq[2].push_back(128'hA0 + 128'(k));
    run_to_idle("single", 20);
    n_checks += 2;
    if (obs_data.size() != 3) begin
      n_fail++; $display("FAIL single_beats got=%0d exp=3", obs_data.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks += 3;
        if (obs_data[k] !== 128'hA0 + 128'(k)) begin n_fail++; $display("FAIL single_data k=%0d got=%h exp=%h", k, obs_data[k], 128'hA0 + 128'(k)); end
        if (obs_id[k] != 2) begin n_fail++; $display("FAIL single_id k=%0d got=%0d exp=2", k, obs_id[k]); end
        if (obs_cyc[k] != k + 1) begin n_fail++; $display("FAIL single_bubble k=%0d got=%0d exp=%0d", k, obs_cyc[k], k + 1); end
      end
    end
    if (m_grants.size() != 1 || m_grants[0] != 2) begin
      n_fail++; $display("FAIL single_grants got=%0d exp=1", m_grants.size());
    end
  endtask

  task automatic test_fairness();
    int n = 0;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    rdy_drv = 1'b1;
    for (int i = 0; i < N; i++) for (int k = 0; k < 40; k++) srcq[i].push_back(beat(i, k));
    while (m_grants.size() < 6 && n < 100) begin run_cycle(); n++; end
    n_checks++;
    if (m_grants.size() < 6) begin
      n_fail++; $display("FAIL fair_timeout got=%0d grants exp=6", m_grants.size());
    end else begin
      for (int g = 0; g < 5; g++) begin
        n_checks += 2;
        if (m_grants[g] != exp_seq[g]) begin n_fail++; $display("FAIL fair_order g=%0d got=%0d exp=%0d", g, m_grants[g], exp_seq[g]); end
        if (m_gbeats[g] != BURST) begin n_fail++; $display("FAIL fair_burst g=%0d got=%0d exp=%0d", g, m_gbeats[g], BURST); end
      end
    end
    n_checks++;
    if (obs_cyc.size() != 40 || obs_cyc[obs_cyc.size()-1] != 44) begin
      n_fail++; $display("FAIL fair_timing got=%0d beats exp=40 ending cycle 44", obs_cyc.size());
    end
    for (int i = 0; i < N; i++) srcq[i].delete();
    run_cycle();
`ifdef OUT_STREAM_ARB_STATS_EN
    begin
      int exp_stat[4] = '{16, 8, 8, 8};
      for (int s = 0; s < N; s++) begin
        stat_sel = IDW'(s);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (stat_beats !== 32'(exp_stat[s])) begin
          n_fail++; $display("FAIL stat_beats sel=%0d got=%0d exp=%0d", s, stat_beats, exp_stat[s]);
        end
      end
      @(posedge clk); #1;
    end
`endif
  endtask

  task automatic test_stall();
    int c = 0;
    apply_reset();
    for (int k = 0; k < 10; k++) srcq[1].push_back(beat(1, k));
    while (c < 60 && (m_owner >= 0 || srcq[1].size() > 0)) begin
      rdy_drv = !(c >= 4 && c <= 8);
      run_cycle();
      if (c >= 4 && c <= 8) begin
        n_checks++;
        if (seen_data !== beat(1, 3)) begin n_fail++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, seen_data, beat(1, 3)); end
      end
      c++;
    end
    n_checks += 2;
    if (m_grants.size() != 2 || m_gbeats[0] != BURST || m_gbeats[1] != 2) begin
      n_fail++; $display("FAIL stall_bursts got=%0d grants exp=2 (8 then 2 beats)", m_grants.size());
    end
    if (obs_cyc.size() != 10 || obs_cyc[7] != 13) begin
      n_fail++; $display("FAIL stall_resume got=%0d beats exp=10 with 8th at cycle 13", obs_cyc.size());
    end
  endtask

  task automatic test_forfeit();
    int c = 0;
    apply_reset();
    rdy_drv = 1'b1;
    for (int k = 0; k < 2; k++) srcq[0].push_back(beat(0, k));
    for (int k = 0; k < 5; k++) srcq[3].push_back(beat(3, k));
    while (c < 40 && (m_owner >= 0 || srcq[0].size() > 0 || srcq[3].size() > 0)) begin
      run_cycle();
      if (c == 4) begin
        n_checks++;
        if (seen_id !== 2'd0) begin n_fail++; $display("FAIL forfeit_idle_id got=%0d exp=0", seen_id); end
      end
      c++;
    end
    n_checks += 2;
    if (m_grants.size() < 2 || m_grants[0] != 0 || m_grants[1] != 3 || m_gbeats[0] != 2) begin
      n_fail++; $display("FAIL forfeit_grants got=%0d grants exp=2 (0 then 3)", m_grants.size());
    end
    if (obs_id.size() != 7 || obs_id[2] != 3) begin
      n_fail++; $display("FAIL forfeit_beats got=%0d beats exp=7", obs_id.size());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    rdy_drv = 1'b1;
    for (int k = 0; k < 20; k++) srcq[2].push_back(beat(2, k));
    repeat (4) run_cycle();
    drive_inputs();
    @(negedge clk);
    n_checks++;
    if (bus.s128_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid got=%b exp=1", bus.s128_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (bus.s128_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", bus.s128_valid); end
    if (bus.s128_data !== '0)    begin n_fail++; $display("FAIL areset_data got=%h exp=0", bus.s128_data); end
    if (bus.req_rdy !== '0)      begin n_fail++; $display("FAIL areset_req_rdy got=%b exp=0", bus.req_rdy); end
    if (bus.s128_id !== '0)      begin n_fail++; $display("FAIL areset_id got=%0d exp=0", bus.s128_id); end
    if (busy !== 1'b0)           begin n_fail++; $display("FAIL areset_busy got=%b exp=0", busy); end
    for (int i = 0; i < N; i++) srcq[i].delete();
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = N - 1; i >= 0; i--) for (int k = 0; k < 3; k++) srcq[i].push_back(beat(i, k));
    run_to_idle("areset", 60);
    n_checks++;
    if (m_grants.size() == 0 || m_grants[0] != 0) begin
      n_fail++; $display("FAIL areset_priority got=%0d exp=0", (m_grants.size() > 0) ? m_grants[0] : -1);
    end
  endtask

  task automatic test_random();
    int total = 0;
    apply_reset();
    rand_mode = 1'b1;
    repeat (400) run_cycle();
    rand_mode = 1'b0;
    rdy_drv = 1'b1;
    gate = '1;
    run_to_idle("random", 200);
    for (int i = 0; i < N; i++) total += m_total[i];
    n_checks++;
    if (obs_data.size() != total) begin
      n_fail++; $display("FAIL random_beat_total got=%0d exp=%0d", obs_data.size(), total);
    end
  endtask

  initial begin
`ifdef OUT_STREAM_ARB_STATS_EN
    stat_sel = '0;
`endif
    rst_n = 1'b0;
    rand_mode = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_forfeit();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
